alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  16-bit datapath ALU of the processor core: add, subtract, multiply, pass-A, pass-B.
//  Result and zero flag are combinational from the operands.
//  A result/flag holding register, clocked by clk, supplies the outputs for NOP selects.
//  Sits between the register-file/accumulator operand buses and the result/write-back bus.
//  The zero flag feeds the control unit for conditional branches.
// PARAMETERS
//  WIDTH   16   operand/result width in bits
// PORTS
//  clk     in   1      system clock, rising-edge active
//  rst     in   1      reset, asynchronous, active-high
//  A       in   WIDTH  operand A
//  B       in   WIDTH  operand B
//  select  in   3      operation code
//  out     out  WIDTH  result
//  z_flag  out  1      zero flag
// BEHAVIOUR
//  Interface: one clock (clk); reset (rst) is asynchronous and active-high.
//  Opcodes:
//   000 ADD   out = A + B, low WIDTH bits; carry discarded.
//   001 SUB   out = B - A, low WIDTH bits; two's-complement wrap when A > B.
//   010 MUL   out = low WIDTH bits of A * B (unsigned); upper half discarded.
//   011 PASSA out = A.
//   100 PASSB out = B.
//   101/110/111 NOP: out = held result register.
//  Combinational path:
//   - Select 000-100: out follows A/B/select in the same delta, zero clock latency.
//   - No output waits for a clock edge.
//  Zero flag:
//   - ADD/SUB: z_flag = (result == 0), combinational.
//   - Other opcodes, NOP included: z_flag = held flag register.
//  Hold registers (res_q, z_q), updated on rising clk:
//   - Select 000-100: res_q <= current combinational out.
//   - ADD/SUB: z_q <= (result == 0). PASSA/PASSB/MUL: z_q unchanged.
//   - NOP: res_q and z_q unchanged.
//  Reset:
//   - rst=1 forces res_q=0 and z_q=0 immediately, independent of clk.
//   - While rst=1, NOP selects drive out=0, z_flag=0.
//   - Non-NOP selects still drive their combinational result during reset.
//   - Reset mid-sequence discards the held result; the first post-reset NOP yields 0.
//  Boundaries:
//   - ADD 0xFFFF+1 = 0x0000, z_flag=1.
//   - SUB with A==B gives 0, z_flag=1.
//   - MUL overflow truncates; no overflow/carry output exists.
//   - X/Z on select: treat as NOP.
// STRUCTURE
//  Shared package alu_pkg:
//   - ALU_WIDTH = 16.
//   - Opcode localparams OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010,
//     OP_PASSA=3'b011, OP_PASSB=3'b100, OP_NOP=3'b111.
//  Single module; no sub-module:
//   - combinational case on select;
//   - one always block with async reset for res_q/z_q;
//   - output mux choosing combinational result vs res_q.
// TESTING (check 10 ns after applying stimulus; clk period 50 ns)
//  1. A=60, B=62, sel=000 -> out=122, z_flag=0.
//  2. A=20, B=40, sel=001 -> out=20, z_flag=0; then A=B=40, sel=001 -> out=0, z_flag=1.
//  3. A=B=40, sel=010 -> out=1600; A=0x0100, B=0x0100 -> out=0x0000 (truncation).
//  4. A=40, B=20, sel=011 -> out=40; then sel=100 -> out=20.
//  5. After sel=100 result 20 is clocked in: sel=111 with A=40, B=20 -> out=20 (held), z_flag=held.
//  6. Assert rst asynchronously mid-clock with sel=111 -> out=0, z_flag=0 immediately.
//     Release rst; remain in NOP -> out stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: operand width and opcode encodings.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_PASSB = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b111;

endpackage

// File: rtl/alu.sv
// 16-bit datapath ALU: add, subtract (B - A), multiply (low half), pass-A,
// pass-B. Results are combinational; a hold register supplies out/z_flag for
// NOP selects (101/110/111 and any unrecognised select value).
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       select,
    output logic [WIDTH-1:0] out,
    output logic             z_flag
);

    logic [WIDTH-1:0] res;
    logic             res_valid;
    logic             z_valid;
    logic             z_comb;
    logic [WIDTH-1:0] res_q;
    logic             z_q;

    // Decode select and compute the combinational result; unmatched selects fall to NOP
    always_comb begin
        res       = '0;
        res_valid = 1'b0;
        z_valid   = 1'b0;
        case (select)
            OP_ADD: begin
                res       = A + B;
                res_valid = 1'b1;
                z_valid   = 1'b1;
            end
            OP_SUB: begin
                res       = B - A;
                res_valid = 1'b1;
                z_valid   = 1'b1;
            end
            OP_MUL: begin
                res       = A * B;
                res_valid = 1'b1;
            end
            OP_PASSA: begin
                res       = A;
                res_valid = 1'b1;
            end
            OP_PASSB: begin
                res       = B;
                res_valid = 1'b1;
            end
            default: begin
                res       = '0;
                res_valid = 1'b0;
                z_valid   = 1'b0;
            end
        endcase
        z_comb = (res == '0);
    end

    // Hold register: capture result for all real ops, flag only for ADD/SUB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            z_q   <= 1'b0;
        end else begin
            if (res_valid) begin
                res_q <= res;
            end
            if (z_valid) begin
                z_q <= z_comb;
            end
        end
    end

    // Output mux: live result/flag when defined for this select, else held values
    always_comb begin
        out    = res_valid ? res : res_q;
        z_flag = z_valid ? z_comb : z_q;
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: reset state, a constant vector table, hand
// sequences for hold/async-reset behaviour, and randomised vectors checked
// against a reference model through a scoreboard queue.
module tb_alu;
    import alu_pkg::*;

    localparam int W = ALU_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [W-1:0] out;
    logic         z;

    always #25 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (a),
        .B     (b),
        .select(sel),
        .out   (out),
        .z_flag(z)
    );

    typedef struct {
        logic [W-1:0] out;
        logic         z;
        string        name;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   sel;
        logic [W-1:0] eout;
        logic         ez;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];

    int n_vec = 0;
    int n_err = 0;

    // reference model of the hold register
    logic [W-1:0] m_res = '0;
    logic         m_z   = 1'b0;

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic [2:0] s);
        exp_t e;
        logic [W:0]     sum;
        logic [2*W-1:0] prod;
        e.name = "model";
        e.out  = m_res;
        e.z    = m_z;
        case (s)
            3'd0: begin
                sum   = {1'b0, ia} + {1'b0, ib};
                e.out = sum[W-1:0];
                e.z   = (e.out == 0);
            end
            3'd1: begin
                e.out = ib - ia;
                e.z   = (ia == ib);
            end
            3'd2: begin
                prod  = {{W{1'b0}}, ia} * {{W{1'b0}}, ib};
                e.out = prod[W-1:0];
            end
            3'd3: e.out = ia;
            3'd4: e.out = ib;
            default: ;
        endcase
        return e;
    endfunction

    task automatic push(input logic [W-1:0] eo, input logic ez, input string nm);
        exp_t e;
        e.out  = eo;
        e.z    = ez;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: no expected entry for out=%h z=%b", out, z);
        end else begin
            e = sb.pop_front();
            if (out !== e.out || z !== e.z) begin
                n_err++;
                $display("FAIL %s: out=%h z_flag=%b, required out=%h z_flag=%b",
                         e.name, out, z, e.out, e.z);
            end
        end
    endtask

    // Drive at negedge, check 10 ns later, clock the hold register, return at next negedge
    task automatic step(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] is,
                        input bit use_model, input logic [W-1:0] eo, input logic ez,
                        input string nm);
        exp_t me;
        a   = ia;
        b   = ib;
        sel = is;
        me  = model(ia, ib, is);
        if (use_model) push(me.out, me.z, nm);
        else           push(eo, ez, nm);
        #10;
        check();
        @(posedge clk);
        if (!rst && is <= 3'd4) begin
            m_res = me.out;
            if (is <= 3'd1) m_z = me.z;
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{16'd0,      16'd0,      3'b111, 16'h0000, 1'b0};
        tbl[1]  = '{16'd60,     16'd62,     3'b000, 16'd122,  1'b0};
        tbl[2]  = '{16'd20,     16'd40,     3'b001, 16'd20,   1'b0};
        tbl[3]  = '{16'd40,     16'd40,     3'b001, 16'd0,    1'b1};
        tbl[4]  = '{16'd40,     16'd40,     3'b010, 16'd1600, 1'b1};
        tbl[5]  = '{16'h0100,   16'h0100,   3'b010, 16'h0000, 1'b1};
        tbl[6]  = '{16'd40,     16'd20,     3'b011, 16'd40,   1'b1};
        tbl[7]  = '{16'd40,     16'd20,     3'b100, 16'd20,   1'b1};
        tbl[8]  = '{16'd40,     16'd20,     3'b111, 16'd20,   1'b1};
        tbl[9]  = '{16'hFFFF,   16'h0001,   3'b000, 16'h0000, 1'b1};
        tbl[10] = '{16'd5,      16'd3,      3'b001, 16'hFFFE, 1'b0};
        tbl[11] = '{16'd1,      16'd2,      3'b110, 16'hFFFE, 1'b0};
        tbl[12] = '{16'h8000,   16'h0002,   3'b010, 16'h0000, 1'b0};
        tbl[13] = '{16'd9,      16'd9,      3'b101, 16'h0000, 1'b0};
        tbl[14] = '{16'd7,      16'd7,      3'b100, 16'd7,    1'b0};
        tbl[15] = '{16'd0,      16'd0,      OP_NOP, 16'd7,    1'b0};

        // reset state: NOP under reset reads zero
        rst = 1'b1;
        a   = 16'd123;
        b   = 16'd1;
        sel = OP_NOP;
        push(16'h0000, 1'b0, "reset_nop");
        #10;
        check();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].a, tbl[i].b, tbl[i].sel, 1'b0, tbl[i].eout, tbl[i].ez,
                 $sformatf("table[%0d]", i));
        end

        // build a nonzero held result with held flag=1
        step(16'd3, 16'd3, OP_SUB,   1'b0, 16'd0, 1'b1, "sub_eq_zero");
        step(16'd5, 16'd0, OP_PASSA, 1'b0, 16'd5, 1'b1, "passa_keep_flag");
        step(16'd0, 16'd0, OP_NOP,   1'b0, 16'd5, 1'b1, "nop_held");

        // asynchronous reset asserted between clock edges
        a   = 16'd40;
        b   = 16'd20;
        sel = OP_NOP;
        #5;
        rst   = 1'b1;
        m_res = '0;
        m_z   = 1'b0;
        push(16'h0000, 1'b0, "async_rst_nop");
        #1;
        check();
        @(negedge clk);

        // non-NOP ops stay live during reset; held values remain zero
        step(16'd9, 16'd4, OP_PASSA, 1'b0, 16'd9, 1'b0, "rst_passa_live");
        step(16'd1, 16'd1, OP_ADD,   1'b0, 16'd2, 1'b0, "rst_add_live");
        step(16'd1, 16'd1, OP_NOP,   1'b0, 16'd0, 1'b0, "rst_nop_zero");
        rst = 1'b0;
        step(16'd8, 16'd8, OP_NOP,   1'b0, 16'd0, 1'b0, "post_rst_nop1");
        step(16'd8, 16'd8, OP_NOP,   1'b0, 16'd0, 1'b0, "post_rst_nop2");

        // randomised vectors checked against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [2:0]   rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rb = ra;
            if (rs == OP_ADD && $urandom_range(0, 3) == 0) rb = W'(0) - ra;
            step(ra, rb, rs, 1'b1, '0, 1'b0, $sformatf("rand[%0d] sel=%0d", i, rs));
        end

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
